cu_seq: RTL and testbench

- Multi-cycle instruction sequencer for the LEGv8-style datapath.
- Owns fetch, decode, execute, memory, writeback and branch timing, and drives the datapath's 36-bit control word every cycle.
- Waits on memory handshakes with a bounded timeout.
- Sits between the instruction register, the memory interface and the datapath register file, ALU and PC.

---
 rtl/cu_pkg.sv | 112 +++++++++++
 rtl/cu_opclass.sv | 67 ++++++
 rtl/cu_seq.sv | 196 +++++++++++++++++++
 tb/tb_cu_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer:
// state encodings, opcodes, control-word bit positions and field codes.
package cu_pkg;

    // Sequencer states; encodings are visible on state_out for debug.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MADDR  = 4'd3,
        S_MWAIT  = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_FAULT  = 4'd15
    } state_t;

    // IR[31:21] opcodes for the supported R-format and D-format ops.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // B and CBZ use shorter opcode fields (IR[31:26] and IR[31:24]).
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    // Control-word bit positions (LSB of each multi-bit field).
    localparam int CW_FS    = 31;
    localparam int CW_SA    = 26;
    localparam int CW_SB    = 21;
    localparam int CW_DA    = 16;
    localparam int CW_WREG  = 15;
    localparam int CW_C0    = 14;
    localparam int CW_MCS   = 12;
    localparam int CW_BSEL  = 11;
    localparam int CW_MEMW  = 10;
    localparam int CW_IRLD  = 9;
    localparam int CW_STLD  = 8;
    localparam int CW_SIZE  = 6;
    localparam int CW_ADDT  = 5;
    localparam int CW_DATT  = 4;
    localparam int CW_PCSEL = 3;
    localparam int CW_PCFS  = 1;

    // ALU function-select codes.
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_EOR = 5'b01100;

    // PC function select.
    localparam logic [1:0] PCFS_HOLD = 2'b00;
    localparam logic [1:0] PCFS_INC  = 2'b01;
    localparam logic [1:0] PCFS_IMM  = 2'b10;

    // Memory chip-select.
    localparam logic [1:0] MCS_IDLE  = 2'b00;
    localparam logic [1:0] MCS_DATA  = 2'b01;
    localparam logic [1:0] MCS_INSTR = 2'b10;

    // Immediate select.
    localparam logic [1:0] KM_NONE = 2'b00;
    localparam logic [1:0] KM_D    = 2'b01;
    localparam logic [1:0] KM_B    = 2'b10;
    localparam logic [1:0] KM_CB   = 2'b11;

    // Access size for data transfers (doubleword).
    localparam logic [1:0] SIZE_DW = 2'b11;

    // Register index of XZR.
    localparam logic [4:0] REG_XZR = 5'd31;

    // ALU operation family; the S variant is carried separately.
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_EOR
    } alu_op_t;

    // One-hot instruction class produced by cu_opclass.
    typedef struct packed {
        logic r_alu;
        logic load;
        logic store;
        logic br;
        logic cbz;
        logic illegal;
    } opclass_t;

    function automatic logic [4:0] alu_fs(input alu_op_t op);
        logic [4:0] fs;
        fs = FS_ADD;
        case (op)
            ALU_ADD: fs = FS_ADD;
            ALU_SUB: fs = FS_SUB;
            ALU_AND: fs = FS_AND;
            ALU_ORR: fs = FS_ORR;
            ALU_EOR: fs = FS_EOR;
            default: fs = FS_ADD;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/cu_opclass.sv
// Combinational opcode classifier: IR[31:21] -> one-hot class + ALU op.
// Ports: i_opcode (IR[31:21]); o_class, o_alu_op, o_set_flags.
module cu_opclass
    import cu_pkg::*;
(
    input  logic [10:0] i_opcode,
    output opclass_t    o_class,
    output alu_op_t     o_alu_op,
    output logic        o_set_flags
);

    always_comb begin
        o_class     = '0;
        o_alu_op    = ALU_ADD;
        o_set_flags = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_ADD;
            end
            OP_ADDS: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_ADD;
                o_set_flags   = 1'b1;
            end
            OP_SUB: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_SUB;
            end
            OP_SUBS: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_SUB;
                o_set_flags   = 1'b1;
            end
            OP_AND: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_AND;
            end
            OP_ANDS: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_AND;
                o_set_flags   = 1'b1;
            end
            OP_ORR: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_ORR;
            end
            OP_EOR: begin
                o_class.r_alu = 1'b1;
                o_alu_op      = ALU_EOR;
            end
            OP_LDUR: o_class.load  = 1'b1;
            OP_STUR: o_class.store = 1'b1;
            default: begin
                // Branch forms carry immediates in the low opcode bits,
                // so only their fixed prefix is compared.
                if (i_opcode[10:5] == OP_B)
                    o_class.br = 1'b1;
                else if (i_opcode[10:3] == OP_CBZ)
                    o_class.cbz = 1'b1;
                else
                    o_class.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle LEGv8 instruction sequencer driving the 36-bit control word.
// Ports: clock, reset_n (sync, active-low), instr, status {N,Z,C,V},
//        mem_ready; state_out, controlWord, k_mux, fault (sticky).
module cu_seq
    import cu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic [3:0]  state_out,
    output logic [35:0] controlWord,
    output logic [1:0]  k_mux,
    output logic        fault
);

    state_t           r_state;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;

    state_t           w_next;
    opclass_t         w_cls;
    alu_op_t          w_alu;
    logic             w_setf;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic             w_waiting;
    logic [35:0]      w_cw;
    logic [1:0]       w_km;
    logic [4:0]       w_rn;
    logic [4:0]       w_rm;
    logic [4:0]       w_rd;
    logic             w_unused;

    assign w_rn = r_ir[9:5];
    assign w_rm = r_ir[20:16];
    assign w_rd = r_ir[4:0];

    // Immediate fields are consumed by the datapath, not the sequencer.
    assign w_unused = ^{r_ir[15:10], status[3], status[1:0]};

    cu_opclass u_opclass (
        .i_opcode    (r_ir[31:21]),
        .o_class     (w_cls),
        .o_alu_op    (w_alu),
        .o_set_flags (w_setf)
    );

    // Timeout fires on the cycle the counter would reach TIMEOUT_CYC;
    // a simultaneous mem_ready takes priority in the next-state logic.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MWAIT);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // IR, wait counter and sticky fault.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ir    <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && mem_ready)
                r_ir <= instr;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_waiting)
                r_cnt <= w_cnt_inc;
            if (w_next == S_FAULT)
                r_fault <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready)
                    w_next = S_DECODE;
                else if (w_timeout)
                    w_next = S_FAULT;
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_cls.r_alu:   w_next = S_EXEC;
                    w_cls.load:    w_next = S_MADDR;
                    w_cls.store:   w_next = S_MADDR;
                    w_cls.br:      w_next = S_BRANCH;
                    w_cls.cbz:     w_next = S_BRANCH;
                    w_cls.illegal: w_next = S_FAULT;
                    default:       w_next = S_FAULT;
                endcase
            end
            S_EXEC:  w_next = S_FETCH;
            S_MADDR: w_next = S_MWAIT;
            S_MWAIT: begin
                if (mem_ready)
                    w_next = w_cls.store ? S_FETCH : S_WB;
                else if (w_timeout)
                    w_next = S_FAULT;
            end
            S_WB:     w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    // Control-word generation.
    always_comb begin
        w_cw = '0;
        w_km = KM_NONE;
        unique case (r_state)
            S_FETCH: begin
                w_cw[CW_MCS +: 2] = MCS_INSTR;
                w_cw[CW_ADDT]     = 1'b1;
                w_cw[CW_IRLD]     = 1'b1;
                if (mem_ready)
                    w_cw[CW_PCFS +: 2] = PCFS_INC;
            end
            S_EXEC: begin
                w_cw[CW_FS +: 5] = alu_fs(w_alu);
                w_cw[CW_SA +: 5] = w_rn;
                w_cw[CW_SB +: 5] = w_rm;
                w_cw[CW_DA +: 5] = w_rd;
                w_cw[CW_WREG]    = 1'b1;
                w_cw[CW_C0]      = (w_alu == ALU_SUB);
                w_cw[CW_STLD]    = w_setf;
            end
            S_MADDR: begin
                w_cw[CW_FS +: 5] = FS_ADD;
                w_cw[CW_SA +: 5] = w_rn;
                w_cw[CW_BSEL]    = 1'b1;
                w_km             = KM_D;
            end
            S_MWAIT: begin
                w_cw[CW_FS +: 5]   = FS_ADD;
                w_cw[CW_SA +: 5]   = w_rn;
                w_cw[CW_BSEL]      = 1'b1;
                w_cw[CW_MCS +: 2]  = MCS_DATA;
                w_cw[CW_SIZE +: 2] = SIZE_DW;
                w_km               = KM_D;
                // Stores drive Rt onto the data bus; loads only address.
                if (w_cls.store) begin
                    w_cw[CW_MEMW]    = 1'b1;
                    w_cw[CW_SB +: 5] = w_rd;
                    w_cw[CW_DATT]    = 1'b1;
                end
            end
            S_WB: begin
                w_cw[CW_DA +: 5]  = w_rd;
                w_cw[CW_WREG]     = 1'b1;
                w_cw[CW_MCS +: 2] = MCS_DATA;
            end
            S_BRANCH: begin
                if (w_cls.br) begin
                    w_cw[CW_PCFS +: 2] = PCFS_IMM;
                    w_cw[CW_PCSEL]     = 1'b1;
                    w_km               = KM_B;
                end else begin
                    // CBZ: pass Rt through the ALU against XZR; the
                    // datapath's registered Z flag decides the branch.
                    w_cw[CW_FS +: 5]   = FS_ADD;
                    w_cw[CW_SA +: 5]   = w_rd;
                    w_cw[CW_SB +: 5]   = REG_XZR;
                    w_cw[CW_PCFS +: 2] = status[2] ? PCFS_IMM : PCFS_HOLD;
                    w_km               = KM_CB;
                end
            end
            default: begin
                w_cw = '0;
                w_km = KM_NONE;
            end
        endcase
    end

    // Control outputs are held quiet for the whole time reset is asserted.
    assign controlWord = reset_n ? w_cw : '0;
    assign k_mux       = reset_n ? w_km : KM_NONE;
    assign state_out   = r_state;
    assign fault       = r_fault;

endmodule

// File: tb/tb_cu_seq.sv
// Self-checking bench for cu_seq: per-cycle stimulus and expected outputs
// are queued together, then driven and compared one cycle at a time.
module tb_cu_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = '0;
    logic [3:0]  status = '0;
    logic        mem_ready = 1'b0;
    logic [3:0]  state_out;
    logic [35:0] controlWord;
    logic [1:0]  k_mux;
    logic        fault;

    cu_seq #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .status      (status),
        .mem_ready   (mem_ready),
        .state_out   (state_out),
        .controlWord (controlWord),
        .k_mux       (k_mux),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] I_ADD  = 32'h8B020023; // ADD X3,X1,X2
    localparam logic [31:0] I_SUBS = 32'hEB0600A5; // SUBS X5,X5,X6
    localparam logic [31:0] I_LDUR = 32'hF8408047; // LDUR X7,[X2,#8]
    localparam logic [31:0] I_STUR = 32'hF8000041; // STUR X1,[X2,#0]
    localparam logic [31:0] I_CBZ  = 32'hB4000044; // CBZ X4,#2
    localparam logic [31:0] I_B    = 32'h14000010; // B #16
    localparam logic [31:0] I_ILL  = 32'h00000000;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic [3:0]  st;
        string       nm;
    } stim_t;

    stim_t       sq[$];
    logic [42:0] eq[$];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [35:0] cw(
        input logic [4:0] fs, input logic [4:0] sa,
        input logic [4:0] sb, input logic [4:0] da,
        input logic wreg, input logic c0, input logic [1:0] mcs,
        input logic bsel, input logic mw, input logic irl,
        input logic stl, input logic [1:0] size, input logic at,
        input logic dt, input logic pcsel, input logic [1:0] pcfs);
        return {fs, sa, sb, da, wreg, c0, mcs, bsel, mw, irl, stl,
                size, at, dt, pcsel, pcfs, 1'b0};
    endfunction

    function automatic logic [35:0] fetch_cw(input logic rdy);
        return cw(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 2'b00, 1, 0, 0,
                  rdy ? 2'b01 : 2'b00);
    endfunction

    task automatic push(input logic rst, input logic [31:0] ins,
                        input logic rdy, input logic [3:0] st,
                        input logic [3:0] es, input logic [35:0] ecw,
                        input logic [1:0] ekm, input logic ef,
                        input string nm);
        stim_t s;
        s.rst = rst; s.ins = ins; s.rdy = rdy; s.st = st; s.nm = nm;
        sq.push_back(s);
        eq.push_back({es, ecw, ekm, ef});
    endtask

    // Advance one clock, apply the next queued stimulus, settle to negedge.
    task automatic apply(output string nm);
        stim_t s;
        @(posedge clock);
        #1;
        s = sq.pop_front();
        reset_n = s.rst;
        instr = s.ins;
        mem_ready = s.rdy;
        status = s.st;
        nm = s.nm;
        @(negedge clock);
    endtask

    task automatic test_reset();
        string nm;
        logic [42:0] e;
        reset_n = 1'b0;
        push(0, 0, 0, 0, 4'd0, 36'h0, 2'b00, 0, "reset0");
        push(0, 0, 1, 0, 4'd0, 36'h0, 2'b00, 0, "reset1");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_add();
        string nm;
        logic [42:0] e;
        push(1, I_ADD, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "add_fetch");
        push(1, I_ADD, 0, 0, 4'd1, 36'h0, 2'b00, 0, "add_decode");
        push(1, I_ADD, 0, 0, 4'd2,
             cw(5'b01000, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b00, 0, "add_exec");
        push(1, I_ADD, 0, 0, 4'd0, fetch_cw(0), 2'b00, 0, "add_refetch");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_subs();
        string nm;
        logic [42:0] e;
        push(1, I_SUBS, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "subs_fetch");
        push(1, I_SUBS, 0, 0, 4'd1, 36'h0, 2'b00, 0, "subs_decode");
        push(1, I_SUBS, 0, 0, 4'd2,
             cw(5'b01001, 5, 6, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
             2'b00, 0, "subs_exec");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_ldur();
        string nm;
        logic [42:0] e;
        logic [35:0] wait_cw;
        wait_cw = cw(5'b01000, 2, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0,
                     2'b11, 0, 0, 0, 0);
        push(1, I_LDUR, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "ld_fetch");
        push(1, I_LDUR, 0, 0, 4'd1, 36'h0, 2'b00, 0, "ld_decode");
        push(1, I_LDUR, 0, 0, 4'd3,
             cw(5'b01000, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b01, 0, "ld_maddr");
        for (int i = 0; i < 3; i++)
            push(1, I_LDUR, 0, 0, 4'd4, wait_cw, 2'b01, 0, "ld_mwait");
        push(1, I_LDUR, 1, 0, 4'd4, wait_cw, 2'b01, 0, "ld_mwait_rdy");
        push(1, I_LDUR, 0, 0, 4'd5,
             cw(0, 0, 0, 7, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b00, 0, "ld_wb");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_branch();
        string nm;
        logic [42:0] e;
        push(1, I_CBZ, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "cbz_t_fetch");
        push(1, I_CBZ, 0, 0, 4'd1, 36'h0, 2'b00, 0, "cbz_t_decode");
        push(1, I_CBZ, 0, 4'b0100, 4'd6,
             cw(5'b01000, 4, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10),
             2'b11, 0, "cbz_taken");
        push(1, I_CBZ, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "cbz_n_fetch");
        push(1, I_CBZ, 0, 0, 4'd1, 36'h0, 2'b00, 0, "cbz_n_decode");
        push(1, I_CBZ, 0, 4'b0000, 4'd6,
             cw(5'b01000, 4, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00),
             2'b11, 0, "cbz_not_taken");
        push(1, I_B, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "b_fetch");
        push(1, I_B, 0, 0, 4'd1, 36'h0, 2'b00, 0, "b_decode");
        push(1, I_B, 1, 0, 4'd6,
             cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10),
             2'b10, 0, "b_branch");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    // 15 idle fetch cycles, then ready on the cycle the timeout would fire.
    task automatic test_back_to_back();
        string nm;
        logic [42:0] e;
        for (int i = 0; i < 15; i++)
            push(1, I_ADD, 0, 0, 4'd0, fetch_cw(0), 2'b00, 0, "edge_wait");
        push(1, I_ADD, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "edge_ready");
        push(1, I_ADD, 0, 0, 4'd1, 36'h0, 2'b00, 0, "edge_decode");
        push(1, I_ADD, 0, 0, 4'd2,
             cw(5'b01000, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b00, 0, "edge_exec");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_stur_timeout();
        string nm;
        logic [42:0] e;
        logic [35:0] st_cw;
        st_cw = cw(5'b01000, 2, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0,
                   2'b11, 0, 1, 0, 0);
        push(1, I_STUR, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "st_fetch");
        push(1, I_STUR, 0, 0, 4'd1, 36'h0, 2'b00, 0, "st_decode");
        push(1, I_STUR, 0, 0, 4'd3,
             cw(5'b01000, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b01, 0, "st_maddr");
        for (int i = 0; i < 16; i++)
            push(1, I_STUR, 0, 0, 4'd4, st_cw, 2'b01, 0, "st_mwait");
        push(1, I_STUR, 1, 0, 4'd15, 36'h0, 2'b00, 1, "st_fault0");
        push(1, I_STUR, 1, 0, 4'd15, 36'h0, 2'b00, 1, "st_fault1");
        push(0, I_STUR, 0, 0, 4'd15, 36'h0, 2'b00, 1, "st_rst_low");
        push(1, I_STUR, 0, 0, 4'd0, fetch_cw(0), 2'b00, 0, "st_recovered");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_illegal();
        string nm;
        logic [42:0] e;
        push(1, I_ILL, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "ill_fetch");
        push(1, I_ILL, 0, 0, 4'd1, 36'h0, 2'b00, 0, "ill_decode");
        push(1, I_ILL, 0, 0, 4'd15, 36'h0, 2'b00, 1, "ill_fault");
        push(0, I_ILL, 0, 0, 4'd15, 36'h0, 2'b00, 1, "ill_rst_low");
        push(1, I_ILL, 0, 0, 4'd0, fetch_cw(0), 2'b00, 0, "ill_recovered");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid_mwait();
        string nm;
        logic [42:0] e;
        push(1, I_LDUR, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "rm_fetch");
        push(1, I_LDUR, 0, 0, 4'd1, 36'h0, 2'b00, 0, "rm_decode");
        push(1, I_LDUR, 0, 0, 4'd3,
             cw(5'b01000, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
             2'b01, 0, "rm_maddr");
        push(1, I_LDUR, 0, 0, 4'd4,
             cw(5'b01000, 2, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 2'b11, 0, 0, 0, 0),
             2'b01, 0, "rm_mwait");
        push(0, I_LDUR, 1, 0, 4'd4, 36'h0, 2'b00, 0, "rm_rst_low");
        push(1, I_LDUR, 0, 0, 4'd0, fetch_cw(0), 2'b00, 0, "rm_fetch_again");
        push(1, I_SUBS, 1, 0, 4'd0, fetch_cw(1), 2'b00, 0, "rm_fetch_rdy");
        push(1, I_SUBS, 0, 0, 4'd1, 36'h0, 2'b00, 0, "rm_decode2");
        push(1, I_SUBS, 0, 0, 4'd2,
             cw(5'b01001, 5, 6, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
             2'b00, 0, "rm_exec");
        while (sq.size() > 0) begin
            apply(nm);
            e = eq.pop_front();
            checks++;
            if ({state_out, controlWord, k_mux, fault} !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d cw=%h km=%b f=%b want st=%0d cw=%h km=%b f=%b",
                         nm, state_out, controlWord, k_mux, fault,
                         e[42:39], e[38:3], e[2:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_subs();
        test_ldur();
        test_branch();
        test_back_to_back();
        test_stur_timeout();
        test_illegal();
        test_reset_mid_mwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
